// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller: drives all eight 3-input rows into a gate under
// test, samples its synchronized output per row, and compares the measured
// table against a programmable expected table.
module tt_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_we,
  input  logic [7:0] cfg_tt,
  input  logic       start,
  input  logic       abort,
  input  logic       gate_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] meas_tt,
  output logic       match,
  output logic [7:0] mismatch_mask
);

  // Terminal value of the settle counter; SETTLE_CYCLES never exceeds 255.
  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StSample = 2'd2,
    StFin    = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] row_q, row_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] exp_q, exp_d;
  logic [7:0] meas_q, meas_d;
  logic [7:0] mask_q, mask_d;
  logic       match_q, match_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [2:0] drive_q, drive_d;
  logic [1:0] sync_q;

  logic       gate_sync;
  logic       settle_last;
  logic       last_row;

  assign gate_sync   = sync_q[1];
  assign settle_last = (cnt_q == SettleLast);
  assign last_row    = (row_q == 3'd7);

  // Two-flop synchronizer for the asynchronous gate output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], gate_out};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; abort is ignored in FIN so a finishing sweep completes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (abort) begin
          state_d = StIdle;
        end else if (settle_last) begin
          state_d = StSample;
        end
      end
      StSample: begin
        if (abort) begin
          state_d = StIdle;
        end else if (last_row) begin
          state_d = StFin;
        end else begin
          state_d = StSettle;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM output / datapath next-state logic for all registered outputs.
  always_comb begin
    row_d   = row_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    meas_d  = meas_q;
    mask_d  = mask_q;
    match_d = match_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    drive_d = drive_q;
    unique case (state_q)
      StIdle: begin
        // Config load and start on the same edge: the sweep uses the new table.
        if (cfg_we) begin
          exp_d = cfg_tt;
        end
        if (start) begin
          row_d   = 3'd0;
          cnt_d   = 8'd0;
          meas_d  = 8'h00;
          busy_d  = 1'b1;
          drive_d = 3'd0;
        end
      end
      StSettle: begin
        if (abort) begin
          cnt_d   = 8'd0;
          busy_d  = 1'b0;
          drive_d = 3'd0;
        end else if (settle_last) begin
          cnt_d = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StSample: begin
        if (abort) begin
          busy_d  = 1'b0;
          drive_d = 3'd0;
        end else begin
          // Row r lands in bit [7-r] so row 000 is the table MSB.
          meas_d[3'd7 - row_q] = gate_sync;
          if (!last_row) begin
            row_d   = row_q + 3'd1;
            drive_d = row_q + 3'd1;
          end
        end
      end
      StFin: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        drive_d = 3'd0;
        match_d = (meas_q == exp_q);
        mask_d  = meas_q ^ exp_q;
      end
      default: begin
        busy_d  = 1'b0;
        drive_d = 3'd0;
      end
    endcase
  end

  // Datapath and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q   <= 3'd0;
      cnt_q   <= 8'd0;
      exp_q   <= 8'h00;
      meas_q  <= 8'h00;
      mask_q  <= 8'h00;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drive_q <= 3'd0;
    end else begin
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      meas_q  <= meas_d;
      mask_q  <= mask_d;
      match_q <= match_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drive_q <= drive_d;
    end
  end

  assign in1           = drive_q[2];
  assign in2           = drive_q[1];
  assign in3           = drive_q[0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign meas_tt       = meas_q;
  assign match         = match_q;
  assign mismatch_mask = mask_q;

endmodule
